// File: rtl/divider_pkg.sv
// cpu_defs: shared divider definitions (state encoding, default width, counter width)
package cpu_defs;
  localparam int DATA_W_DEF = 32;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
  localparam int CNT_W = cnt_w(DATA_W_DEF);
  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_SIGN, DIV_DONE} div_state_t;
endpackage

// File: rtl/divider_step.sv
// div_step: one combinational restoring-division step
//   rem, quo, divisor : current partial remainder, quotient/dividend shift reg, divisor magnitude
//   rem_n, quo_n      : values after shifting {rem, quo} left and trying the subtraction
module div_step #(parameter int W = 32) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_n,
  output logic [W-1:0] quo_n
);
  logic [W:0] sh, trial;
  // trial[W] set means the shifted remainder is below the divisor, so restore
  always_comb begin
    sh = {rem, quo[W-1]};
    trial = sh - {1'b0, divisor};
    rem_n = trial[W] ? sh[W-1:0] : trial[W-1:0];
    quo_n = {quo[W-2:0], !trial[W]};
  end
endmodule

// File: rtl/divider.sv
// divider: multicycle signed restoring divider with start/end handshake
//   clk, reset (async, active-low)
//   a_in, b_in      : dividend / divisor, sampled on the start edge
//   div_control     : start request, honoured only in IDLE
//   div_unsigned    : DIVU select, present only with DIV_UNSIGNED_EN defined
//   hi_out, lo_out  : remainder / quotient, registered and held
//   div_end         : one-cycle completion pulse; div_zero flags a zero divisor
module divider
  import cpu_defs::*;
#(parameter int DATA_W = DATA_W_DEF) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              div_control,
`ifdef DIV_UNSIGNED_EN
  input  logic              div_unsigned,
`endif
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              div_end,
  output logic              div_zero
);
  localparam int CW = cnt_w(DATA_W);
  div_state_t state, state_n;
  logic [DATA_W-1:0] rem, quo, dvs, rem_n, quo_n;
  logic [CW-1:0] cnt;
  logic neg_q, neg_r, uns, zero, a_neg, b_neg, load, dz, step, fin;
`ifdef DIV_UNSIGNED_EN
  assign uns = div_unsigned;
`else
  assign uns = 1'b0;
`endif
  assign zero = b_in == '0;
  assign a_neg = !uns && a_in[DATA_W-1];
  assign b_neg = !uns && b_in[DATA_W-1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= DIV_IDLE;
    else state <= state_n;
  always_comb
    state_n = state == DIV_IDLE ? (div_control ? (zero ? DIV_DONE : DIV_CALC) : DIV_IDLE) :
              state == DIV_CALC ? (cnt == '0 ? DIV_SIGN : DIV_CALC) :
              state == DIV_SIGN ? DIV_DONE : DIV_IDLE;
  always_comb begin
    load = state == DIV_IDLE && div_control && !zero;
    dz = state == DIV_IDLE && div_control && zero;
    step = state == DIV_CALC;
    fin = state == DIV_SIGN;
  end
  div_step #(.W(DATA_W)) u_step (
    .rem(rem),
    .quo(quo),
    .divisor(dvs),
    .rem_n(rem_n),
    .quo_n(quo_n)
  );
  // magnitudes are unsigned, so 0x80000000 negates to itself and still divides correctly
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
      div_end <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      if (load) begin
        rem <= '0;
        quo <= a_neg ? -a_in : a_in;
        dvs <= b_neg ? -b_in : b_in;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        cnt <= CW'(DATA_W - 1);
      end
      if (step) begin
        rem <= rem_n;
        quo <= quo_n;
        cnt <= cnt == '0 ? cnt : cnt - CW'(1);
      end
      if (fin) begin
        lo_out <= neg_q ? -quo : quo;
        hi_out <= neg_r ? -rem : rem;
      end
      div_end <= fin || dz;
      div_zero <= dz;
    end
endmodule
